// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores, RISC-V style load extension
// and a fixed-latency handshake that allows one outstanding request at a time.
module data_mem #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_width,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_fault
);
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_cnt;
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rspWord;
  logic [1:0]  r_rspOff;
  logic [2:0]  r_rspWidth;
  logic        r_rspLoad;
  logic        r_rspFault;

  logic              w_accept;
  logic              w_write;
  logic              w_fault;
  logic              w_badWidth;
  logic              w_misaligned;
  logic              w_outOfRange;
  logic [ADDR_W-3:0] w_wordIdx;
  logic [1:0]        w_off;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_wdataLanes;
  logic [31:0]       w_shifted;

  assign w_accept     = i_req_valid && (r_state == IDLE) && !i_rst;
  assign w_wordIdx    = i_addr[ADDR_W-1:2];
  assign w_off        = i_addr[1:0];
  assign w_outOfRange = (i_addr >> ADDR_W) != 32'd0;
  assign w_fault      = w_badWidth | w_misaligned | w_outOfRange;
  assign w_write      = w_accept && i_we && !w_fault;

  always_comb begin
    w_badWidth   = 1'b0;
    w_misaligned = 1'b0;
    case (i_width)
      3'b000, 3'b100: w_misaligned = 1'b0;
      3'b001, 3'b101: w_misaligned = i_addr[0];
      3'b010:         w_misaligned = (w_off != 2'b00);
      default:        w_badWidth   = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_byteEn     = 4'b0000;
    w_wdataLanes = i_wdata;
    case (i_width[1:0])
      2'b00: begin
        w_byteEn     = 4'b0001 << w_off;
        w_wdataLanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_byteEn     = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdataLanes = {2{i_wdata[15:0]}};
      end
      2'b10:   w_byteEn = 4'b1111;
      default: w_byteEn = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_write && w_byteEn[b]) begin
        r_mem[w_wordIdx][8*b +: 8] <= w_wdataLanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rspWord  <= '0;
      r_rspOff   <= '0;
      r_rspWidth <= '0;
      r_rspLoad  <= 1'b0;
      r_rspFault <= 1'b0;
    end else if (w_accept) begin
      r_rspWord  <= r_mem[w_wordIdx];
      r_rspOff   <= w_off;
      r_rspWidth <= i_width;
      r_rspLoad  <= !i_we;
      r_rspFault <= w_fault;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (r_cnt == 2'd0) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == IDLE);
    o_rsp_valid = (r_state == RESP);
    o_fault     = 1'b0;
    o_rdata     = '0;
    w_shifted   = r_rspWord >> {r_rspOff, 3'b000};
    if (r_state == RESP) begin
      o_fault = r_rspFault;
      if (r_rspLoad && !r_rspFault) begin
        case (r_rspWidth)
          3'b000:  o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
          3'b001:  o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
          3'b010:  o_rdata = r_rspWord;
          3'b100:  o_rdata = {24'd0, w_shifted[7:0]};
          3'b101:  o_rdata = {16'd0, w_shifted[15:0]};
          default: o_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Exercises data_mem at LATENCY 1 and 3 with directed and random traffic; a
// byte-addressed reference model is compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_data_mem;
  localparam int AW   = 14;
  localparam int MEMB = 2 ** AW;

  logic        clk = 1'b0;
  logic [1:0]  rstv = 2'b00;
  logic [1:0]  reqValid = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr [2];
  logic [2:0]  width [2];
  logic [31:0] wdata [2];
  logic [1:0]  ready;
  logic [1:0]  rspValid;
  logic [1:0]  fault;
  logic [31:0] rdata [2];
  int          checks = 0;
  int          errors = 0;
  bit          cmpOn = 1'b0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] w);
    return (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit refFault(input logic [31:0] a, input logic [2:0] w);
    if (w == 3'b011 || w == 3'b110 || w == 3'b111) return 1'b1;
    if ((w == 3'b001 || w == 3'b101) && a[0]) return 1'b1;
    if (w == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    if (longint'(a) >= longint'(MEMB)) return 1'b1;
    return 1'b0;
  endfunction

  // Gathers the accessed bytes into the low end and fills the rest by extension.
  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] w);
    int          sz = sizeOf(w);
    logic [31:0] v  = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(int'(off)+i) +: 8];
    if (!w[2] && sz < 4 && v[8*sz-1]) begin
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int LAT = (g == 0) ? 1 : 3;

    data_mem #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .i_clk      (clk),
      .i_rst      (rstv[g]),
      .i_req_valid(reqValid[g]),
      .o_req_ready(ready[g]),
      .i_we       (we[g]),
      .i_addr     (addr[g]),
      .i_width    (width[g]),
      .i_wdata    (wdata[g]),
      .o_rsp_valid(rspValid[g]),
      .o_rdata    (rdata[g]),
      .o_fault    (fault[g])
    );

    logic [7:0]  mMem [MEMB];
    int          mEdge = 0;
    int          mNext = 0;
    int          mRspEdge = -100;
    logic [31:0] mRdata = '0;
    logic        mFault = 1'b0;
    int          wb;
    int          aIdx;

    assign wb   = int'({addr[g][AW-1:2], 2'b00});
    assign aIdx = int'(addr[g][AW-1:0]);

    // Edge k accepts when k >= mNext; the response is visible after edge k+LAT-1.
    always @(posedge clk or posedge rstv[g]) begin
      if (rstv[g]) begin
        mNext    <= 0;
        mRspEdge <= -100;
      end else begin
        mEdge <= mEdge + 1;
        if (reqValid[g] && (mEdge + 1 >= mNext)) begin
          mNext    <= mEdge + LAT + 2;
          mRspEdge <= mEdge + LAT;
          mFault   <= refFault(addr[g], width[g]);
          mRdata   <= (we[g] || refFault(addr[g], width[g])) ? 32'd0 :
                      refLoad({mMem[wb+3], mMem[wb+2], mMem[wb+1], mMem[wb]}, addr[g][1:0], width[g]);
          if (we[g] && !refFault(addr[g], width[g])) begin
            for (int i = 0; i < sizeOf(width[g]); i++) mMem[aIdx + i] <= wdata[g][8*i +: 8];
          end
        end
      end
    end

    initial begin
      bit ev;
      wait (cmpOn);
      forever begin
        @(negedge clk);
        if (rstv[g]) begin
          checkOutput($sformatf("L%0d reset ready", LAT), {31'd0, ready[g]}, 32'd1);
          checkOutput($sformatf("L%0d reset rspValid", LAT), {31'd0, rspValid[g]}, 32'd0);
          checkOutput($sformatf("L%0d reset rdata", LAT), rdata[g], 32'd0);
          checkOutput($sformatf("L%0d reset fault", LAT), {31'd0, fault[g]}, 32'd0);
        end else begin
          ev = (mEdge == mRspEdge);
          checkOutput($sformatf("L%0d ready", LAT), {31'd0, ready[g]}, {31'd0, (mEdge + 1 >= mNext)});
          checkOutput($sformatf("L%0d rspValid", LAT), {31'd0, rspValid[g]}, {31'd0, ev});
          checkOutput($sformatf("L%0d rdata", LAT), rdata[g], ev ? mRdata : 32'd0);
          checkOutput($sformatf("L%0d fault", LAT), {31'd0, fault[g]}, {31'd0, ev & mFault});
        end
      end
    end
  end

  // Holds the request until accepted; returns just after the accept edge.
  task automatic waitAccept(input int g, output bit accepted);
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = ready[g];
      @(posedge clk);
      #1;
    end
    reqValid[g] = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout inst %0d: got no accept, expected one within 20 cycles", g);
    end
  endtask

  task automatic applyStimulus(input int g, input bit iwe, input logic [31:0] a, input logic [2:0] w,
                               input logic [31:0] d, output logic [31:0] rd, output bit f, output int lt);
    bit accepted;
    rd = '0;
    f  = 1'b0;
    lt = 0;
    we[g] = iwe; addr[g] = a; width[g] = w; wdata[g] = d; reqValid[g] = 1'b1;
    waitAccept(g, accepted);
    if (!accepted) return;
    // Inputs wander while busy; the response must not notice.
    we[g] = 1'($urandom); addr[g] = $urandom; width[g] = 3'($urandom);
    wdata[g] = $urandom; reqValid[g] = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rspValid[g]) begin
        rd = rdata[g];
        f  = fault[g];
        lt = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    reqValid[g] = 1'b0;
    if (lt == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL response timeout inst %0d: got no response, expected one within 8 cycles", g);
    end
  endtask

  task automatic expectRsp(input int g, input string tag, input logic [31:0] rd, input bit f, input int lt,
                           input logic [31:0] expRd, input bit expF);
    int lat = (g == 0) ? 1 : 3;
    checkOutput($sformatf("L%0d %s rdata", lat, tag), rd, expRd);
    checkOutput($sformatf("L%0d %s fault", lat, tag), {31'd0, f}, {31'd0, expF});
    checkOutput($sformatf("L%0d %s latency", lat, tag), 32'(lt), 32'(lat));
  endtask

  task automatic resetDuring(input int g, input bit iwe, input logic [31:0] a, input logic [31:0] d);
    bit accepted;
    we[g] = iwe; addr[g] = a; width[g] = 3'b010; wdata[g] = d; reqValid[g] = 1'b1;
    waitAccept(g, accepted);
    rstv[g] = 1'b1;
    #1;
    checkOutput($sformatf("inst %0d ready at reset", g), {31'd0, ready[g]}, 32'd1);
    checkOutput($sformatf("inst %0d rspValid at reset", g), {31'd0, rspValid[g]}, 32'd0);
    @(posedge clk);
    #1;
    rstv[g] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("inst %0d no rsp after reset", g), {31'd0, rspValid[g]}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runInstance(input int g);
    logic [31:0] rd;
    bit          f;
    int          lt;
    int          acc[$];
    logic [31:0] a;

    for (int i = 0; i < 16; i++) applyStimulus(g, 1'b1, 32'(i * 4), 3'b010, $urandom, rd, f, lt);

    applyStimulus(g, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, f, lt);
    expectRsp(g, "SW 0x10", rd, f, lt, 32'h0, 1'b0);
    applyStimulus(g, 1'b0, 32'h10, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x10", rd, f, lt, 32'hDEADBEEF, 1'b0);

    applyStimulus(g, 1'b1, 32'h20, 3'b010, 32'h11223344, rd, f, lt);
    applyStimulus(g, 1'b1, 32'h22, 3'b000, 32'h000000AA, rd, f, lt);
    expectRsp(g, "SB 0x22", rd, f, lt, 32'h0, 1'b0);
    applyStimulus(g, 1'b0, 32'h20, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x20", rd, f, lt, 32'h11AA3344, 1'b0);
    applyStimulus(g, 1'b0, 32'h22, 3'b000, 32'h0, rd, f, lt);
    expectRsp(g, "LB 0x22", rd, f, lt, 32'hFFFFFFAA, 1'b0);
    applyStimulus(g, 1'b0, 32'h22, 3'b100, 32'h0, rd, f, lt);
    expectRsp(g, "LBU 0x22", rd, f, lt, 32'h000000AA, 1'b0);
    applyStimulus(g, 1'b0, 32'h22, 3'b001, 32'h0, rd, f, lt);
    expectRsp(g, "LH 0x22", rd, f, lt, 32'h000011AA, 1'b0);

    applyStimulus(g, 1'b1, 32'h0, 3'b010, 32'h55667788, rd, f, lt);
    applyStimulus(g, 1'b0, 32'h21, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x21", rd, f, lt, 32'h0, 1'b1);
    applyStimulus(g, 1'b1, 32'h23, 3'b001, 32'hFFFF, rd, f, lt);
    expectRsp(g, "SH 0x23", rd, f, lt, 32'h0, 1'b1);
    applyStimulus(g, 1'b0, 32'h20, 3'b011, 32'h0, rd, f, lt);
    expectRsp(g, "width 011", rd, f, lt, 32'h0, 1'b1);
    applyStimulus(g, 1'b1, 32'(MEMB), 3'b010, 32'hBADBAD00, rd, f, lt);
    expectRsp(g, "SW out of range", rd, f, lt, 32'h0, 1'b1);
    applyStimulus(g, 1'b0, 32'h20, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x20 after faults", rd, f, lt, 32'h11AA3344, 1'b0);
    applyStimulus(g, 1'b0, 32'h0, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x0 after faults", rd, f, lt, 32'h55667788, 1'b0);

    // Back-to-back loads with valid held high: accepts are LATENCY+1 edges apart.
    we[g] = 1'b0; addr[g] = 32'h10; width[g] = 3'b010; reqValid[g] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready[g]) acc.push_back(i);
      @(posedge clk);
      #1;
    end
    reqValid[g] = 1'b0;
    checkOutput($sformatf("inst %0d accept spacing", g),
                (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'd0, (g == 0) ? 32'd2 : 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready[g]) break;
    end
    @(posedge clk);
    #1;

    resetDuring(g, 1'b1, 32'h3C, 32'hCAFEF00D);
    applyStimulus(g, 1'b0, 32'h3C, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x3C after reset", rd, f, lt, 32'hCAFEF00D, 1'b0);
    resetDuring(g, 1'b0, 32'h3C, 32'h0);
    applyStimulus(g, 1'b0, 32'h3C, 3'b010, 32'h0, rd, f, lt);
    expectRsp(g, "LW 0x3C after aborted load", rd, f, lt, 32'hCAFEF00D, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a[$urandom_range(AW, 31)] = 1'b1;
      applyStimulus(g, 1'($urandom), a, 3'($urandom), $urandom, rd, f, lt);
      checkOutput($sformatf("inst %0d random latency", g), 32'(lt), (g == 0) ? 32'd1 : 32'd3);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      addr[g]  = '0;
      width[g] = '0;
      wdata[g] = '0;
    end
    #1;
    rstv  = 2'b11;
    cmpOn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstv = 2'b00;
    runInstance(0);
    runInstance(1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
